// File: rtl/decode_cycle_if.sv
// IF/ID-to-ID/EX signal bundle for the RV32I decode stage.
// master drives the fetch/writeback/hazard side; slave is the decode stage itself.
interface decode_cycle_if;
   logic [31:0] InstrD;
   logic [31:0] PCD;
   logic [31:0] PCPlus4D;
   logic        RegWriteW;
   logic [4:0]  RDW;
   logic [31:0] ResultW;
   logic        FlushE;

   logic        RegWriteE;
   logic [1:0]  ResultSrcE;
   logic        MemWriteE;
   logic        JumpE;
   logic        BranchE;
   logic        ALUSrcE;
   logic [2:0]  ALUControlE;
   logic [31:0] RD1_E;
   logic [31:0] RD2_E;
   logic [31:0] Imm_Ext_E;
   logic [4:0]  RS1_E;
   logic [4:0]  RS2_E;
   logic [4:0]  RD_E;
   logic [31:0] PCE;
   logic [31:0] PCPlus4E;
   logic        ValidE;
   logic        IllegalE;

   modport master (
      output InstrD, PCD, PCPlus4D, RegWriteW, RDW, ResultW, FlushE,
      input  RegWriteE, ResultSrcE, MemWriteE, JumpE, BranchE, ALUSrcE, ALUControlE,
             RD1_E, RD2_E, Imm_Ext_E, RS1_E, RS2_E, RD_E, PCE, PCPlus4E, ValidE, IllegalE
   );

   modport slave (
      input  InstrD, PCD, PCPlus4D, RegWriteW, RDW, ResultW, FlushE,
      output RegWriteE, ResultSrcE, MemWriteE, JumpE, BranchE, ALUSrcE, ALUControlE,
             RD1_E, RD2_E, Imm_Ext_E, RS1_E, RS2_E, RD_E, PCE, PCPlus4E, ValidE, IllegalE
   );
endinterface

// File: rtl/decode_cycle.sv
// RV32I decode stage: register file, control decoder, immediate extender, ID/EX register.
// One cycle InstrD -> E outputs; no backpressure (no stall input), flush loads a bubble.
module decode_cycle #(
   parameter int XLEN           = 32,
   parameter int NOP_ON_ILLEGAL = 1
) (
   input logic           clk,
   input logic           rst,
   decode_cycle_if.slave dif
);
   localparam logic [6:0] OP_R    = 7'b0110011;
   localparam logic [6:0] OP_I    = 7'b0010011;
   localparam logic [6:0] OP_LW   = 7'b0000011;
   localparam logic [6:0] OP_SW   = 7'b0100011;
   localparam logic [6:0] OP_BEQ  = 7'b1100011;
   localparam logic [6:0] OP_JAL  = 7'b1101111;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

   typedef struct packed {
      logic            reg_write;
      logic [1:0]      result_src;
      logic            mem_write;
      logic            jump;
      logic            branch;
      logic            alu_src;
      logic [2:0]      alu_ctl;
      logic [XLEN-1:0] rd1;
      logic [XLEN-1:0] rd2;
      logic [XLEN-1:0] imm;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [4:0]      rd;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] pc4;
      logic            valid;
      logic            illegal;
   } idex_t;

   idex_t           idex_q, idex_d;
   logic [XLEN-1:0] rf_q [32];

   logic [6:0]      opcode;
   logic [2:0]      funct3;
   logic [4:0]      rs1, rs2, rd;
   logic [31:0]     instr;
   logic            legal;

   assign instr  = dif.InstrD;
   assign opcode = instr[6:0];
   assign rd     = instr[11:7];
   assign funct3 = instr[14:12];
   assign rs1    = instr[19:15];
   assign rs2    = instr[24:20];

   // sub only exists for R-type; I-type bit 30 is part of the immediate.
   function automatic logic [2:0] alu_sel(input logic [2:0] f3, input logic is_sub);
      case (f3)
         3'b000:  alu_sel = is_sub ? ALU_SUB : ALU_ADD;
         3'b111:  alu_sel = ALU_AND;
         3'b110:  alu_sel = ALU_OR;
         3'b010:  alu_sel = ALU_SLT;
         default: alu_sel = ALU_ADD;
      endcase
   endfunction

   // x0 is never written, so it stays at its reset value of 0; the bypass must still skip it.
   function automatic logic [XLEN-1:0] rf_read(input logic [4:0] idx);
      if (idx == 5'd0)
         rf_read = '0;
      else if (dif.RegWriteW && dif.RDW == idx)
         rf_read = dif.ResultW;
      else
         rf_read = rf_q[idx];
   endfunction

   always_comb begin
      idex_d = '0;
      legal  = 1'b1;
      case (opcode)
         OP_R: begin
            idex_d.reg_write = 1'b1;
            idex_d.alu_ctl   = alu_sel(funct3, instr[30]);
         end
         OP_I: begin
            idex_d.reg_write = 1'b1;
            idex_d.alu_src   = 1'b1;
            idex_d.alu_ctl   = alu_sel(funct3, 1'b0);
            idex_d.imm       = {{20{instr[31]}}, instr[31:20]};
         end
         OP_LW: begin
            idex_d.reg_write  = 1'b1;
            idex_d.alu_src    = 1'b1;
            idex_d.result_src = 2'b01;
            idex_d.imm        = {{20{instr[31]}}, instr[31:20]};
         end
         OP_SW: begin
            idex_d.mem_write = 1'b1;
            idex_d.alu_src   = 1'b1;
            idex_d.imm       = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         end
         OP_BEQ: begin
            idex_d.branch  = 1'b1;
            idex_d.alu_ctl = ALU_SUB;
            idex_d.imm     = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
         end
         OP_JAL: begin
            idex_d.jump       = 1'b1;
            idex_d.reg_write  = 1'b1;
            idex_d.result_src = 2'b10;
            idex_d.imm        = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
         end
         default: legal = 1'b0;
      endcase

      idex_d.rd1   = rf_read(rs1);
      idex_d.rd2   = rf_read(rs2);
      idex_d.rs1   = rs1;
      idex_d.rs2   = rs2;
      idex_d.rd    = rd;
      idex_d.pc    = dif.PCD;
      idex_d.pc4   = dif.PCPlus4D;
      idex_d.valid = 1'b1;

      // Flush outranks the illegal flag: a flushed slot reports nothing.
      if (dif.FlushE || !legal) begin
         idex_d         = '0;
         idex_d.illegal = !legal && !dif.FlushE && (NOP_ON_ILLEGAL != 0);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         idex_q <= '0;
         for (int i = 0; i < 32; i++)
            rf_q[i] <= '0;
      end else begin
         idex_q <= idex_d;
         if (dif.RegWriteW && dif.RDW != 5'd0)
            rf_q[dif.RDW] <= dif.ResultW;
      end
   end

   assign dif.RegWriteE   = idex_q.reg_write;
   assign dif.ResultSrcE  = idex_q.result_src;
   assign dif.MemWriteE   = idex_q.mem_write;
   assign dif.JumpE       = idex_q.jump;
   assign dif.BranchE     = idex_q.branch;
   assign dif.ALUSrcE     = idex_q.alu_src;
   assign dif.ALUControlE = idex_q.alu_ctl;
   assign dif.RD1_E       = idex_q.rd1;
   assign dif.RD2_E       = idex_q.rd2;
   assign dif.Imm_Ext_E   = idex_q.imm;
   assign dif.RS1_E       = idex_q.rs1;
   assign dif.RS2_E       = idex_q.rs2;
   assign dif.RD_E        = idex_q.rd;
   assign dif.PCE         = idex_q.pc;
   assign dif.PCPlus4E    = idex_q.pc4;
   assign dif.ValidE      = idex_q.valid;
   assign dif.IllegalE    = idex_q.illegal;
endmodule
